// File: rtl/alu_seq_pkg.sv
// Shared types and widths for the ALU command sequencer.
// State encoding and the opcode that terminates a sweep live here.
package alu_seq_pkg;

    localparam int OPC_W = 3;
    localparam int DATA_W = 8;
    localparam int RES_W = 16;
    localparam logic [OPC_W-1:0] OPC_LAST = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_HOLD  = 2'd2
    } state_e;

endpackage

// File: rtl/alu_cmd_sequencer.sv
// Command front end for ALU_8bit: registers operands onto the ALU, waits a settle
// interval, captures Result/flags and hands them back over a valid/ready channel.
module alu_cmd_sequencer
    import alu_seq_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [OPC_W-1:0]  cmd_opcode,
    input  logic [DATA_W-1:0] cmd_op1,
    input  logic [DATA_W-1:0] cmd_op2,
    input  logic              cmd_chain,
    input  logic              cmd_sweep,
    output logic [OPC_W-1:0]  alu_opcode,
    output logic [DATA_W-1:0] alu_op1,
    output logic [DATA_W-1:0] alu_op2,
    input  logic [RES_W-1:0]  alu_result,
    input  logic              alu_flagC,
    input  logic              alu_flagZ,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [RES_W-1:0]  rsp_result,
    output logic              rsp_flagC,
    output logic              rsp_flagZ,
    output logic [OPC_W-1:0]  rsp_opcode,
    output logic              rsp_last,
    output logic [7:0]        rsp_count
);

    // Both channels: a transfer happens on a rising edge where valid and ready are both high.
    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              sweep_q, sweep_d;
    logic              chain_q, chain_d;
    logic [DATA_W-1:0] last_result_q, last_result_d;
    logic [OPC_W-1:0]  alu_opcode_q, alu_opcode_d;
    logic [DATA_W-1:0] alu_op1_q, alu_op1_d;
    logic [DATA_W-1:0] alu_op2_q, alu_op2_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [RES_W-1:0]  rsp_result_q, rsp_result_d;
    logic              rsp_flagc_q, rsp_flagc_d;
    logic              rsp_flagz_q, rsp_flagz_d;
    logic [OPC_W-1:0]  rsp_opcode_q, rsp_opcode_d;
    logic              rsp_last_q, rsp_last_d;
    logic [7:0]        rsp_count_q, rsp_count_d;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        sweep_d       = sweep_q;
        chain_d       = chain_q;
        last_result_d = last_result_q;
        alu_opcode_d  = alu_opcode_q;
        alu_op1_d     = alu_op1_q;
        alu_op2_d     = alu_op2_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_result_d  = rsp_result_q;
        rsp_flagc_d   = rsp_flagc_q;
        rsp_flagz_d   = rsp_flagz_q;
        rsp_opcode_d  = rsp_opcode_q;
        rsp_last_d    = rsp_last_q;
        rsp_count_d   = rsp_count_q;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    alu_opcode_d = cmd_sweep ? '0 : cmd_opcode;
                    alu_op1_d    = cmd_chain ? last_result_q : cmd_op1;
                    alu_op2_d    = cmd_op2;
                    sweep_d      = cmd_sweep;
                    chain_d      = cmd_chain;
                    cnt_d        = '0;
                    state_d      = ST_DRIVE;
                end
            end
            ST_DRIVE: begin
                if (cnt_q == SETTLE_LAST) begin
                    rsp_result_d  = alu_result;
                    rsp_flagc_d   = alu_flagC;
                    rsp_flagz_d   = alu_flagZ;
                    rsp_opcode_d  = alu_opcode_q;
                    rsp_last_d    = !sweep_q || (alu_opcode_q == OPC_LAST);
                    last_result_d = alu_result[DATA_W-1:0];
                    rsp_valid_d   = 1'b1;
                    cnt_d         = '0;
                    state_d       = ST_HOLD;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            ST_HOLD: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    rsp_count_d = rsp_count_q + 8'd1;
                    // Returning to IDLE costs a cycle, so no command can slip in on this edge.
                    if (rsp_last_q) begin
                        state_d = ST_IDLE;
                    end else begin
                        alu_opcode_d = alu_opcode_q + 3'd1;
                        alu_op1_d    = chain_q ? last_result_q : alu_op1_q;
                        cnt_d        = '0;
                        state_d      = ST_DRIVE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            sweep_q       <= 1'b0;
            chain_q       <= 1'b0;
            last_result_q <= '0;
            alu_opcode_q  <= '0;
            alu_op1_q     <= '0;
            alu_op2_q     <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_result_q  <= '0;
            rsp_flagc_q   <= 1'b0;
            rsp_flagz_q   <= 1'b0;
            rsp_opcode_q  <= '0;
            rsp_last_q    <= 1'b0;
            rsp_count_q   <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            sweep_q       <= sweep_d;
            chain_q       <= chain_d;
            last_result_q <= last_result_d;
            alu_opcode_q  <= alu_opcode_d;
            alu_op1_q     <= alu_op1_d;
            alu_op2_q     <= alu_op2_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_result_q  <= rsp_result_d;
            rsp_flagc_q   <= rsp_flagc_d;
            rsp_flagz_q   <= rsp_flagz_d;
            rsp_opcode_q  <= rsp_opcode_d;
            rsp_last_q    <= rsp_last_d;
            rsp_count_q   <= rsp_count_d;
        end
    end

    assign cmd_ready  = (state_q == ST_IDLE);
    assign alu_opcode = alu_opcode_q;
    assign alu_op1    = alu_op1_q;
    assign alu_op2    = alu_op2_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_result = rsp_result_q;
    assign rsp_flagC  = rsp_flagc_q;
    assign rsp_flagZ  = rsp_flagz_q;
    assign rsp_opcode = rsp_opcode_q;
    assign rsp_last   = rsp_last_q;
    assign rsp_count  = rsp_count_q;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Self-checking bench for alu_cmd_sequencer: a queue-based response model plus
// directed literal cases, with a second instance at SETTLE_CYCLES=4.
module tb_alu_cmd_sequencer;

    typedef struct packed {
        logic [15:0] res;
        logic        c;
        logic        z;
        logic [2:0]  opc;
        logic        last;
        logic [7:0]  op1;
        logic [7:0]  op2;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [2:0]  cmd_opcode = '0;
    logic [7:0]  cmd_op1 = '0;
    logic [7:0]  cmd_op2 = '0;
    logic        cmd_chain = 1'b0;
    logic        cmd_sweep = 1'b0;
    logic [2:0]  alu_opcode;
    logic [7:0]  alu_op1, alu_op2;
    logic [15:0] alu_result;
    logic        alu_flagC, alu_flagZ;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [15:0] rsp_result;
    logic        rsp_flagC, rsp_flagZ;
    logic [2:0]  rsp_opcode;
    logic        rsp_last;
    logic [7:0]  rsp_count;

    logic        s4_rst = 1'b1;
    logic        s4_cmd_valid = 1'b0;
    logic        s4_cmd_ready;
    logic [2:0]  s4_cmd_opcode = '0;
    logic [7:0]  s4_cmd_op1 = '0;
    logic [7:0]  s4_cmd_op2 = '0;
    logic        s4_cmd_chain = 1'b0;
    logic        s4_cmd_sweep = 1'b0;
    logic [2:0]  s4_alu_opcode;
    logic [7:0]  s4_alu_op1, s4_alu_op2;
    logic [15:0] s4_alu_result;
    logic        s4_alu_flagC, s4_alu_flagZ;
    logic        s4_rsp_valid;
    logic        s4_rsp_ready = 1'b1;
    logic [15:0] s4_rsp_result;
    logic        s4_rsp_flagC, s4_rsp_flagZ;
    logic [2:0]  s4_rsp_opcode;
    logic        s4_rsp_last;
    logic [7:0]  s4_rsp_count;

    int n_checks = 0;
    int n_pass = 0;

    exp_t        exp_q[$];
    logic [15:0] got_q[$];
    logic [7:0]  m_last = '0;
    logic [7:0]  m_count = '0;
    logic        rand_ready = 1'b0;
    logic        ready_fixed = 1'b1;

    localparam logic [15:0] SWEEP_EXP [8] = '{16'h55AA, 16'h55AB, 16'h55A8, 16'h55A9,
                                              16'h55AE, 16'h55AF, 16'h55AC, 16'h55AD};

    always #5 clk = ~clk;

    // ALU stubs: Result = {op2,op1} ^ opcode, C = opcode[0], Z = (Result == 0)
    always_comb begin
        alu_result = {alu_op2, alu_op1} ^ {13'b0, alu_opcode};
        alu_flagC  = alu_opcode[0];
        alu_flagZ  = (alu_result == 16'h0);
        s4_alu_result = {s4_alu_op2, s4_alu_op1} ^ {13'b0, s4_alu_opcode};
        s4_alu_flagC  = s4_alu_opcode[0];
        s4_alu_flagZ  = (s4_alu_result == 16'h0);
    end

    alu_cmd_sequencer #(.SETTLE_CYCLES(1)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_opcode(cmd_opcode),
        .cmd_op1(cmd_op1), .cmd_op2(cmd_op2), .cmd_chain(cmd_chain), .cmd_sweep(cmd_sweep),
        .alu_opcode(alu_opcode), .alu_op1(alu_op1), .alu_op2(alu_op2),
        .alu_result(alu_result), .alu_flagC(alu_flagC), .alu_flagZ(alu_flagZ),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_flagC(rsp_flagC), .rsp_flagZ(rsp_flagZ), .rsp_opcode(rsp_opcode),
        .rsp_last(rsp_last), .rsp_count(rsp_count)
    );

    alu_cmd_sequencer #(.SETTLE_CYCLES(4)) dut4 (
        .clk(clk), .rst(s4_rst),
        .cmd_valid(s4_cmd_valid), .cmd_ready(s4_cmd_ready), .cmd_opcode(s4_cmd_opcode),
        .cmd_op1(s4_cmd_op1), .cmd_op2(s4_cmd_op2), .cmd_chain(s4_cmd_chain), .cmd_sweep(s4_cmd_sweep),
        .alu_opcode(s4_alu_opcode), .alu_op1(s4_alu_op1), .alu_op2(s4_alu_op2),
        .alu_result(s4_alu_result), .alu_flagC(s4_alu_flagC), .alu_flagZ(s4_alu_flagZ),
        .rsp_valid(s4_rsp_valid), .rsp_ready(s4_rsp_ready), .rsp_result(s4_rsp_result),
        .rsp_flagC(s4_rsp_flagC), .rsp_flagZ(s4_rsp_flagZ), .rsp_opcode(s4_rsp_opcode),
        .rsp_last(s4_rsp_last), .rsp_count(s4_rsp_count)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Behavioural model: expand one command into the responses it must produce.
    task automatic model_cmd(input logic [2:0] opc, input logic [7:0] op1, input logic [7:0] op2,
                             input logic chain, input logic sweep);
        int steps;
        exp_t e;
        steps = sweep ? 8 : 1;
        for (int i = 0; i < steps; i++) begin
            e.opc  = sweep ? 3'(i) : opc;
            e.op1  = chain ? m_last : op1;
            e.op2  = op2;
            e.res  = {op2, e.op1} ^ {13'b0, e.opc};
            e.c    = e.opc[0];
            e.z    = (e.res == 16'h0);
            e.last = (i == steps - 1);
            m_last = e.res[7:0];
            exp_q.push_back(e);
        end
    endtask

    // Single driver of rsp_ready; updates land after the main process's #1 writes.
    always @(posedge clk) begin
        #2;
        rsp_ready = rand_ready ? ($urandom_range(0, 3) != 0) : ready_fixed;
    end

    // Compare process: every cycle outside reset.
    always @(negedge clk) begin
        if (!rst) begin
            check("cmd_ready_busy", cmd_ready, exp_q.size() == 0);
            if (rsp_valid) begin
                if (exp_q.size() == 0) begin
                    check("rsp_unexpected", 1, 0);
                end else begin
                    check("rsp_result", rsp_result, exp_q[0].res);
                    check("rsp_flagC", rsp_flagC, exp_q[0].c);
                    check("rsp_flagZ", rsp_flagZ, exp_q[0].z);
                    check("rsp_opcode", rsp_opcode, exp_q[0].opc);
                    check("rsp_last", rsp_last, exp_q[0].last);
                    check("rsp_count", rsp_count, m_count);
                    check("alu_opcode", alu_opcode, exp_q[0].opc);
                    check("alu_op1", alu_op1, exp_q[0].op1);
                    check("alu_op2", alu_op2, exp_q[0].op2);
                    if (rsp_ready) begin
                        got_q.push_back(rsp_result);
                        void'(exp_q.pop_front());
                        m_count = m_count + 8'd1;
                    end
                end
            end
        end
    end

    task automatic send_cmd(input logic [2:0] opc, input logic [7:0] op1, input logic [7:0] op2,
                            input logic chain, input logic sweep);
        int n;
        n = 0;
        @(posedge clk); #1;
        while (!cmd_ready && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        if (!cmd_ready) check("cmd_ready_timeout", 0, 1);
        cmd_valid  = 1'b1;
        cmd_opcode = opc;
        cmd_op1    = op1;
        cmd_op2    = op2;
        cmd_chain  = chain;
        cmd_sweep  = sweep;
        @(posedge clk); #1;
        cmd_valid  = 1'b0;
        cmd_opcode = 3'($urandom_range(0, 7));
        cmd_op1    = 8'($urandom_range(0, 255));
        cmd_op2    = 8'($urandom_range(0, 255));
        cmd_chain  = 1'($urandom_range(0, 1));
        cmd_sweep  = 1'($urandom_range(0, 1));
        model_cmd(opc, op1, op2, chain, sweep);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || !cmd_ready) && n < 5000) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 5000) check("idle_timeout", 0, 1);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        exp_q.delete();
        m_count = '0;
        m_last  = '0;
        #2;
        rst = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int hs;
        logic seen;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_outs_a", {alu_opcode, alu_op1, alu_op2, rsp_valid}, 0);
        check("rst_outs_b", {rsp_result, rsp_flagC, rsp_flagZ, rsp_opcode, rsp_last, rsp_count}, 0);

        // Chain with no prior result feeds 0 into Operand1.
        send_cmd(3'd5, 8'hFF, 8'h12, 1'b1, 1'b0);
        check("chain_from_reset_op1", alu_op1, 8'h00);
        @(posedge clk); #1;
        check("chain_from_reset_res", rsp_result, 16'h1205);
        wait_idle();
        do_reset();

        // Single command, one-cycle latency.
        send_cmd(3'd3, 8'hAA, 8'h55, 1'b0, 1'b0);
        check("t1_not_early", rsp_valid, 0);
        @(posedge clk); #1;
        check("t1_valid", rsp_valid, 1);
        check("t1_result", rsp_result, 16'h55A9);
        check("t1_flags", {rsp_flagC, rsp_flagZ}, 2'b10);
        check("t1_opcode_last", {rsp_opcode, rsp_last}, {3'd3, 1'b1});
        @(posedge clk); #1;
        check("t1_count", rsp_count, 8'd1);
        check("t1_valid_drop", rsp_valid, 0);
        wait_idle();

        // Chain from previous result.
        send_cmd(3'd0, 8'h3C, 8'h55, 1'b1, 1'b0);
        check("chain_op1", alu_op1, 8'hA9);
        @(posedge clk); #1;
        check("chain_result", rsp_result, 16'h55A9);
        wait_idle();

        // Zero flag boundary.
        send_cmd(3'd2, 8'h02, 8'h00, 1'b0, 1'b0);
        @(posedge clk); #1;
        check("zero_result", {rsp_result, rsp_flagC, rsp_flagZ}, {16'h0000, 1'b0, 1'b1});
        wait_idle();

        // Sweep.
        got_q.delete();
        send_cmd(3'd6, 8'hAA, 8'h55, 1'b0, 1'b1);
        wait_idle();
        check("sweep_len", got_q.size(), 8);
        for (int i = 0; i < 8; i++)
            if (i < got_q.size()) check($sformatf("sweep_res%0d", i), got_q[i], SWEEP_EXP[i]);

        // Backpressure.
        ready_fixed = 1'b0;
        send_cmd(3'd6, 8'h0F, 8'hF0, 1'b0, 1'b0);
        n = 0;
        while (!rsp_valid && n < 20) begin @(posedge clk); #1; n++; end
        check("bp_valid_seen", rsp_valid, 1);
        repeat (5) begin
            @(posedge clk); #1;
            check("bp_hold_valid", rsp_valid, 1);
            check("bp_hold_result", rsp_result, 16'hF009);
            check("bp_cmd_ready", cmd_ready, 0);
        end
        ready_fixed = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("bp_accepted", rsp_valid, 0);
        wait_idle();

        // Randomized mix with random response backpressure.
        rand_ready = 1'b1;
        for (int i = 0; i < 40; i++)
            send_cmd(3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                     ($urandom_range(0, 2) == 0), ($urandom_range(0, 4) == 0));
        wait_idle();
        rand_ready = 1'b0;
        repeat (2) @(posedge clk);

        // Response counter wrap.
        do_reset();
        for (int i = 0; i < 255; i++)
            send_cmd(3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                     1'($urandom_range(0, 1)), 1'b0);
        wait_idle();
        check("count_ff", rsp_count, 8'hFF);
        send_cmd(3'd1, 8'h01, 8'h02, 1'b0, 1'b0);
        wait_idle();
        check("count_wrap", rsp_count, 8'h00);

        // SETTLE_CYCLES=4 instance.
        @(posedge clk); #1;
        s4_rst = 1'b0;
        check("s4_rst_cmd_ready", s4_cmd_ready, 1);
        s4_cmd_valid = 1'b1; s4_cmd_opcode = 3'd1; s4_cmd_op1 = 8'h10; s4_cmd_op2 = 8'h20;
        @(posedge clk); #1;
        s4_cmd_valid = 1'b0;
        n = 0;
        while (!s4_rsp_valid && n < 20) begin @(posedge clk); #1; n++; end
        check("s4_latency", n, 4);
        check("s4_result", s4_rsp_result, 16'h2011);
        n = 0;
        while (!s4_cmd_ready && n < 20) begin @(posedge clk); #1; n++; end
        check("s4_idle", s4_cmd_ready, 1);
        s4_cmd_valid = 1'b1; s4_cmd_sweep = 1'b1; s4_cmd_op1 = 8'hAA; s4_cmd_op2 = 8'h55;
        @(posedge clk); #1;
        s4_cmd_valid = 1'b0;
        s4_cmd_sweep = 1'b0;
        hs = 0;
        n = 0;
        while (hs < 2 && n < 100) begin
            @(negedge clk);
            if (s4_rsp_valid && s4_rsp_ready) hs++;
            n++;
        end
        check("s4_two_steps", hs, 2);
        @(posedge clk); #1;
        check("s4_step3_opcode", s4_alu_opcode, 3'd2);
        @(posedge clk); #1;
        s4_rst = 1'b1;
        #1;
        check("s4_mid_rst_ready", s4_cmd_ready, 1);
        check("s4_mid_rst_a", {s4_alu_opcode, s4_alu_op1, s4_alu_op2, s4_rsp_valid}, 0);
        check("s4_mid_rst_b", {s4_rsp_result, s4_rsp_flagC, s4_rsp_flagZ, s4_rsp_opcode,
                               s4_rsp_last, s4_rsp_count}, 0);
        @(posedge clk); #1;
        s4_rst = 1'b0;
        seen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (s4_rsp_valid) seen = 1'b1;
        end
        check("s4_no_rsp_after_rst", seen, 0);
        check("s4_count_after_rst", s4_rsp_count, 8'd0);

        check("exp_q_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/alu_cmd_sequencer.md
Name: alu_cmd_sequencer

Overview:
- Upstream command stage for ALU_8bit: accepts operand/opcode commands over valid/ready, drives the ALU's Opcode/Operand1/Operand2 from registers, waits a settle interval, captures Result/flagC/flagZ and returns them over a valid/ready response channel.
- Supports chaining (previous Result[7:0] becomes Operand1) and an opcode sweep (opcodes 0..7 on one operand pair), replacing hand-written stimulus loops with a hardware sequencer.

Parameters:
- SETTLE_CYCLES, 1, clocks between driving ALU inputs and sampling ALU outputs (legal range 1..15).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  sequencer can accept a command (high only in IDLE).
- cmd_opcode  in  3  ALU opcode; ignored when cmd_sweep=1.
- cmd_op1  in  8  Operand1; ignored when cmd_chain=1.
- cmd_op2  in  8  Operand2.
- cmd_chain  in  1  use last captured Result[7:0] as Operand1.
- cmd_sweep  in  1  issue opcodes 0..7 in order, one response each.
- alu_opcode  out  3  to ALU Opcode.
- alu_op1  out  8  to ALU Operand1.
- alu_op2  out  8  to ALU Operand2.
- alu_result  in  16  from ALU Result.
- alu_flagC  in  1  from ALU flagC.
- alu_flagZ  in  1  from ALU flagZ.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts response.
- rsp_result  out  16  captured Result.
- rsp_flagC  out  1  captured flagC.
- rsp_flagZ  out  1  captured flagZ.
- rsp_opcode  out  3  opcode that produced this response.
- rsp_last  out  1  final response of the current command.
- rsp_count  out  8  responses completed since reset, wraps 255->0.

Behaviour:
- Reset (async, active-high): state=IDLE; every output 0 except cmd_ready=1; last_result=0; settle counter=0. Reset mid-command abandons it with no response, including mid-sweep.
- States: IDLE -> DRIVE -> HOLD -> (DRIVE | IDLE).
- IDLE: cmd_ready=1. Accept on clk edge with cmd_valid&cmd_ready. At that edge, load alu_opcode (cmd_opcode, or 0 if sweep), alu_op2=cmd_op2, alu_op1 (cmd_op1, or last_result[7:0] if chain), latch sweep/chain, counter=0, go DRIVE.
- DRIVE: ALU outputs held stable. Counter increments each clock. On the SETTLE_CYCLES-th edge after entry, capture alu_result/flags into rsp_*, set rsp_opcode=alu_opcode, update last_result, and set rsp_last (=!sweep, or sweep && alu_opcode==7). Then rsp_valid=1 and go HOLD.
- Latency: rsp_valid rises exactly SETTLE_CYCLES clocks after the accept edge (or after the previous step's response handshake).
- HOLD: rsp_* stable while rsp_valid=1 && !rsp_ready. On rsp_valid&rsp_ready edge: rsp_valid=0, rsp_count+1.
  - If rsp_last, go IDLE; cmd_ready is high the following cycle, with no same-cycle command accept.
  - Else alu_opcode+1, alu_op1 = chain ? new last_result[7:0] : unchanged; go DRIVE.
- Chain with no prior result uses 0. Chain in sweep applies to every step.
- alu_* outputs retain last values in IDLE; they are not cleared after a command.
- cmd_* inputs are sampled only at accept; later changes are ignored.
- rsp_count wraps 8'hFF -> 8'h00 without saturation.

Decomposition:
- Shared package alu_seq_pkg: state enum (IDLE, DRIVE, HOLD), OPC_W=3, DATA_W=8, RES_W=16, OPC_LAST=3'd7.
- Single module; no sub-module. The settle counter is inline (4 bits).

Test Plan (bench ALU stub: Result = {op2,op1} ^ {13'b0,opcode}, flagC = opcode[0], flagZ = (Result==0)):
- Reset then single cmd opcode=3, op1=AA, op2=55, rsp_ready=1 -> rsp_valid 1 clk after accept; rsp_result=55A9, C=1, Z=0, rsp_opcode=3, rsp_last=1, rsp_count=1.
- Sweep op1=AA, op2=55 -> 8 responses: 55AA,55AB,55A8,55A9,55AE,55AF,55AC,55AD; opcodes 0..7; rsp_last only on the 8th; cmd_ready low throughout.
- Chain after the first test: opcode=0, op2=55, chain=1 -> alu_op1=A9, rsp_result=55A9. Chain straight from reset -> alu_op1=00.
- Backpressure: rsp_ready=0 for 5 clks -> rsp_* stable and cmd_ready=0; response accepted on the first rsp_ready=1 edge.
- SETTLE_CYCLES=4: rsp_valid rises exactly 4 clks after accept. Assert rst during step 3 of a sweep -> all outputs zero, cmd_ready=1, no further responses, rsp_count=0.
- Run 256 single commands -> rsp_count wraps to 00.
